// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter and sequencer for the shared ALU datapath.
//
// Each operation moves through three states:
//   IDLE  - accepts one request from the arbitration winner
//   ISSUE - drives the ALU from registered operands for one cycle
//   RESP  - holds the captured result until the consumer takes it
//
// Arbitration is round-robin by default. Defining ALU_ARB_FIXED_PRIO_EN gives
// requester 0 fixed priority instead. last_grant is still tracked in that mode.
//
// Ports:
//   clock, reset                  clock and asynchronous active-high reset
//   req{0,1}_valid/ready          request handshakes
//   req{0,1}_a/b/sel              request operands and ALU select
//   alu_a, alu_b, alu_sel         registered operands driven to the ALU
//   alu_out                       combinational ALU result
//   rsp_valid/ready, rsp_data     response handshake and captured result
//   rsp_id                        requester index of the response
//   busy                          state is not IDLE
//   op_count                      completed response handshakes, wrapping
module alu_arbiter #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W:0]   alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W:0]   rsp_data,
  output logic              rsp_id,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W:0]   rsp_data_q, rsp_data_d;
  logic              rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic grant;
  logic accept;

  // Winner index. With a single valid requester it wins outright.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant_q;
`endif
    end
  end

  assign req0_ready = (state_q == StIdle) && req0_valid && !grant;
  assign req1_ready = (state_q == StIdle) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          alu_a_d      = grant ? req1_a : req0_a;
          alu_b_d      = grant ? req1_b : req0_b;
          alu_sel_d    = grant ? req1_sel : req0_sel;
          rsp_id_d     = grant;
          last_grant_d = grant;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        rsp_data_d  = alu_out;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != StIdle);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an operation-level reference model checked on every
// falling edge, plus directed scenarios with literal expected values.
module tb_alu_arbiter;

  localparam int DW = 4;
  localparam int SW = 3;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [SW-1:0] req0_sel = '0, req1_sel = '0;
  logic [DW-1:0] alu_a, alu_b;
  logic [SW-1:0] alu_sel;
  logic [DW:0]   alu_out;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW:0]   rsp_data;
  logic          rsp_id;
  logic          busy;
  logic [CW-1:0] op_count;

  int cmps = 0;
  int errs = 0;

  alu_arbiter #(.DATA_W(DW), .SEL_W(SW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
  );

  always #5 clock = ~clock;

  // Environment ALU; sel 0 is add, so 15+0 gives 15.
  function automatic logic [DW:0] alu_fn(logic [DW-1:0] a, logic [DW-1:0] b,
                                         logic [SW-1:0] s);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a, 1'b0};
      3'd6:    return {2'b00, a[DW-1:1]};
      default: return {1'b1, ~a};
    endcase
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_sel);

  // Who should win given the two valids and the previous grant.
  function automatic int winner(logic v0, logic v1, int last);
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return 1 - last;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  // Reference model: one operation in flight, tracked by its phase.
  int          m_phase = 0;  // 0 waiting for request, 1 computing, 2 awaiting consumer
  int          m_last = 1;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic [SW-1:0] m_sel = '0;
  logic          m_valid = 1'b0;
  logic [DW:0]   m_data = '0;
  int            m_id = 0;
  int            m_done = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_last <= 1; m_a <= '0; m_b <= '0; m_sel <= '0;
      m_valid <= 1'b0; m_data <= '0; m_id <= 0; m_done <= 0;
    end else if (m_phase == 0) begin
      if (req0_valid || req1_valid) begin
        if (winner(req0_valid, req1_valid, m_last) == 1) begin
          m_a <= req1_a; m_b <= req1_b; m_sel <= req1_sel; m_id <= 1; m_last <= 1;
        end else begin
          m_a <= req0_a; m_b <= req0_b; m_sel <= req0_sel; m_id <= 0; m_last <= 0;
        end
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_data  <= alu_fn(m_a, m_b, m_sel);
      m_valid <= 1'b1;
      m_phase <= 2;
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
      m_done  <= m_done + 1;
      m_phase <= 0;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    int w;
    w = winner(req0_valid, req1_valid, m_last);
    check("m_req0_ready", 32'(req0_ready),
          32'(m_phase == 0 && req0_valid && w == 0));
    check("m_req1_ready", 32'(req1_ready),
          32'(m_phase == 0 && req1_valid && w == 1));
    check("m_alu_a", 32'(alu_a), 32'(m_a));
    check("m_alu_b", 32'(alu_b), 32'(m_b));
    check("m_alu_sel", 32'(alu_sel), 32'(m_sel));
    check("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("m_rsp_data", 32'(rsp_data), 32'(m_data));
    check("m_rsp_id", 32'(rsp_id), 32'(m_id));
    check("m_busy", 32'(busy), 32'(m_phase != 0));
    check("m_op_count", 32'(op_count), 32'(m_done % 256));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_a = 0; req1_b = 0; req1_sel = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic wait_rsp(string name);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      cmps++;
      errs++;
      $display("FAIL %s: rsp_valid=%b after 20 cycles, required 1", name, rsp_valid);
    end
  endtask

  int exp_ids[4];

  initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 0, 1};
`endif
    #1;
    do_reset();

    // Reset state.
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_op_count", 32'(op_count), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);

    // Single request from req0: 15 + 0.
    rsp_ready = 1;
    req0_valid = 1; req0_a = 4'd15; req0_b = 4'd0; req0_sel = 3'd0;
    #1 check("single_ready", 32'(req0_ready), 1);
    step();                       // accept edge N
    req0_valid = 0;
    check("single_issue_busy", 32'(busy), 1);
    check("single_issue_rv", 32'(rsp_valid), 0);
    step();                       // edge N+1
    check("single_rv", 32'(rsp_valid), 1);
    check("single_data", 32'(rsp_data), 15);
    check("single_id", 32'(rsp_id), 0);
    step();                       // handshake
    check("single_count", 32'(op_count), 1);
    check("single_idle", 32'(busy), 0);

    // Reset mid-ISSUE discards the operation and clears the count.
    req0_valid = 1; req0_a = 4'd9; req0_b = 4'd2; req0_sel = 3'd1;
    step();                       // accepted, now in ISSUE
    check("rmid_pre_alu_a", 32'(alu_a), 9);
    #1 reset = 1;
    #1;
    check("rmid_rv", 32'(rsp_valid), 0);
    check("rmid_busy", 32'(busy), 0);
    check("rmid_count", 32'(op_count), 0);
    check("rmid_alu_a", 32'(alu_a), 0);
    check("rmid_alu_sel", 32'(alu_sel), 0);
    reset = 0;
    step();                       // first edge after release accepts
    check("rmid_reaccept", 32'(busy), 1);
    req0_valid = 0;
    step();
    step();

    // Contention from reset.
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd2; req0_sel = 3'd0;
    req1_valid = 1; req1_a = 4'd6; req1_b = 4'd3; req1_sel = 3'd2;
    for (int i = 0; i < 4; i++) begin
      wait_rsp("cont_wait");
      check($sformatf("cont_id%0d", i), 32'(rsp_id), 32'(exp_ids[i]));
      check($sformatf("cont_data%0d", i), 32'(rsp_data), exp_ids[i] == 0 ? 3 : 2);
      step();
    end

    // Backpressure: result held while consumer stalls.
    do_reset();
    req1_valid = 1; req1_a = 4'd3; req1_b = 4'd4; req1_sel = 3'd0;
    step();
    req0_valid = 1; req0_a = 4'd5;
    wait_rsp("bp_wait");
    for (int i = 0; i < 5; i++) begin
      check("bp_data", 32'(rsp_data), 7);
      check("bp_id", 32'(rsp_id), 1);
      check("bp_r0", 32'(req0_ready), 0);
      check("bp_r1", 32'(req1_ready), 0);
      check("bp_busy", 32'(busy), 1);
      step();
    end
    rsp_ready = 1;
    step();
    check("bp_release_busy", 32'(busy), 0);
    check("bp_release_rv", 32'(rsp_valid), 0);
    clear_inputs();
    step();

    // Operand isolation: req0 wiggles while req1's operation is in flight.
    do_reset();
    req1_valid = 1; req1_a = 4'd15; req1_b = 4'd15; req1_sel = 3'd7;
    step();
    req1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_a = 4'(i + 2); req0_b = 4'(i * 3); req0_sel = 3'(i);
      check("iso_alu_a", 32'(alu_a), 15);
      check("iso_alu_b", 32'(alu_b), 15);
      check("iso_alu_sel", 32'(alu_sel), 7);
      step();
    end
    check("iso_data", 32'(rsp_data), 32'h10);
    clear_inputs();
    rsp_ready = 1;
    step();

    // Counter wrap after 256 completions.
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 4'd2; req0_b = 4'd1; req0_sel = 3'd4;
    for (int i = 0; i < 256; i++) begin
      wait_rsp("wrap_wait");
      if (i == 255) check("wrap_pre", 32'(op_count), 255);
      step();
    end
    check("wrap_zero", 32'(op_count), 0);
    clear_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
